// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches the word at PC over a req/ready/rvalid
// handshake into the instruction register, and guards the response with a timeout.
`timescale 1ns/1ps
module ifetch_unit #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        PC_Reset,
   input  logic        PC_LdEn,
   input  logic        PC_Sel,
   input  logic        Fetch_Req,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instr,
   output logic        Instr_Valid,
   output logic [31:0] PC,
   output logic        Busy,
   output logic        Fetch_Err
);

   localparam int unsigned    CntW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax    = CntW'(TIMEOUT - 1);
   localparam logic [31:0]    PcResetAln = {PC_RESET[31:2], 2'b00};

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic [31:0]       r_pc;
   logic [31:0]       w_pc_nxt;
   logic [31:0]       r_ir;
   logic [31:0]       w_ir_nxt;
   logic              r_instr_valid;
   logic              w_instr_valid_nxt;
   logic [31:0]       r_addr;
   logic [31:0]       w_addr_nxt;
   logic [CntW-1:0]   r_cnt;
   logic [CntW-1:0]   w_cnt_nxt;
   logic              r_fetch_err;
   logic              w_fetch_err_nxt;

   logic [31:0]       w_pc_plus4;
   logic [31:0]       w_br_off;
   logic [31:0]       w_pc_target;

   // Branch offset is a signed word displacement taken from the low half of IR.
   assign w_pc_plus4  = r_pc + 32'd4;
   assign w_br_off    = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
   assign w_pc_target = w_pc_plus4 + w_br_off;

   // PC is updated independently of the fetch FSM; an in-flight request uses r_addr.
   always_comb begin
      w_pc_nxt = r_pc;
      if (PC_Reset) begin
         w_pc_nxt = PcResetAln;
      end else if (PC_LdEn) begin
         w_pc_nxt = PC_Sel ? w_pc_target : w_pc_plus4;
      end
      w_pc_nxt[1:0] = 2'b00;
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_ir_nxt          = r_ir;
      w_instr_valid_nxt = r_instr_valid;
      w_addr_nxt        = r_addr;
      w_cnt_nxt         = r_cnt;
      w_fetch_err_nxt   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (Fetch_Req) begin
               w_addr_nxt        = {r_pc[31:2], 2'b00};
               w_instr_valid_nxt = 1'b0;
               w_state_nxt       = StReq;
            end
         end
         StReq: begin
            if (imem_ready) begin
               w_cnt_nxt   = '0;
               w_state_nxt = StWait;
            end
         end
         StWait: begin
            // Data arriving on the timeout edge still wins over the error.
            if (imem_rvalid) begin
               w_ir_nxt          = imem_rdata;
               w_instr_valid_nxt = 1'b1;
               w_state_nxt       = StIdle;
            end else if (r_cnt == CntMax) begin
               w_ir_nxt          = 32'h0000_0000;
               w_instr_valid_nxt = 1'b1;
               w_fetch_err_nxt   = 1'b1;
               w_state_nxt       = StIdle;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state       <= StIdle;
         r_pc          <= PcResetAln;
         r_ir          <= 32'h0000_0000;
         r_instr_valid <= 1'b0;
         r_addr        <= 32'h0000_0000;
         r_cnt         <= '0;
         r_fetch_err   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_ir          <= w_ir_nxt;
         r_instr_valid <= w_instr_valid_nxt;
         r_addr        <= w_addr_nxt;
         r_cnt         <= w_cnt_nxt;
         r_fetch_err   <= w_fetch_err_nxt;
      end
   end

   assign imem_req    = (r_state == StReq);
   assign imem_addr   = r_addr;
   assign Instr       = r_ir;
   assign Instr_Valid = r_instr_valid;
   assign PC          = r_pc;
   assign Busy        = (r_state != StIdle);
   assign Fetch_Err   = r_fetch_err;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: expected instruction words are queued when the memory
// response is driven and popped when the DUT reports Instr_Valid.
`timescale 1ns/1ps
module tb_ifetch_unit;

   logic        Clk;
   logic        Reset_n;
   logic        PC_Reset;
   logic        PC_LdEn;
   logic        PC_Sel;
   logic        Fetch_Req;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] Instr;
   logic        Instr_Valid;
   logic [31:0] PC;
   logic        Busy;
   logic        Fetch_Err;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] sb_q[$];

   ifetch_unit #(
      .PC_RESET (32'h0000_0000),
      .TIMEOUT  (16)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .PC_Reset    (PC_Reset),
      .PC_LdEn     (PC_LdEn),
      .PC_Sel      (PC_Sel),
      .Fetch_Req   (Fetch_Req),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .Instr       (Instr),
      .Instr_Valid (Instr_Valid),
      .PC          (PC),
      .Busy        (Busy),
      .Fetch_Err   (Fetch_Err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Bounded wait for Instr_Valid, then compare IR against the scoreboard head.
   task automatic wait_valid(input string tag);
      logic [31:0] exp;
      for (int i = 0; i < 40 && !Instr_Valid; i++) tick();
      check({tag, "_valid"}, {31'd0, Instr_Valid}, 32'd1);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
      check({tag, "_instr"}, Instr, exp);
   endtask

   task automatic fetch(input string tag, input logic [31:0] data);
      imem_ready = 1'b1;
      Fetch_Req  = 1'b1;
      tick();
      Fetch_Req  = 1'b0;
      tick();
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      sb_q.push_back(data);
      tick();
      imem_rvalid = 1'b0;
      wait_valid(tag);
   endtask

   task automatic pc_step(input logic sel);
      PC_LdEn = 1'b1;
      PC_Sel  = sel;
      tick();
      PC_LdEn = 1'b0;
      PC_Sel  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset_n     = 1'b0;
      PC_Reset    = 1'b0;
      PC_LdEn     = 1'b0;
      PC_Sel      = 1'b0;
      Fetch_Req   = 1'b0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      tick();
      tick();
      check("rst_pc", PC, 32'h0);
      check("rst_instr", Instr, 32'h0);
      check("rst_valid", {31'd0, Instr_Valid}, 32'd0);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_err", {31'd0, Fetch_Err}, 32'd0);
      Reset_n = 1'b1;

      // Basic fetch with ready already high and rvalid two cycles after launch.
      imem_ready = 1'b1;
      Fetch_Req  = 1'b1;
      tick();
      Fetch_Req  = 1'b0;
      check("f1_req", {31'd0, imem_req}, 32'd1);
      check("f1_addr", imem_addr, 32'h0);
      check("f1_busy", {31'd0, Busy}, 32'd1);
      tick();
      check("f1_req_drop", {31'd0, imem_req}, 32'd0);
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h8C22_0004;
      sb_q.push_back(32'h8C22_0004);
      tick();
      imem_rvalid = 1'b0;
      wait_valid("f1");
      check("f1_pc", PC, 32'h0);
      check("f1_idle", {31'd0, Busy}, 32'd0);

      // PC increment and branch arithmetic.
      fetch("f2", 32'h1000_003F);
      pc_step(1'b1);
      check("br_to_100", PC, 32'h0000_0100);
      pc_step(1'b0);
      check("pc_plus4", PC, 32'h0000_0104);
      fetch("f3", 32'h1000_FFFE);
      pc_step(1'b1);
      check("br_back", PC, 32'h0000_0100);
      fetch("f4", 32'h0000_FFBE);
      pc_step(1'b1);
      check("br_to_top", PC, 32'hFFFF_FFFC);
      pc_step(1'b0);
      check("pc_wrap", PC, 32'h0);
      pc_step(1'b0);
      check("pc_4", PC, 32'h4);
      PC_Reset = 1'b1;
      pc_step(1'b1);
      PC_Reset = 1'b0;
      check("pc_reset_prio", PC, 32'h0);

      // Stalled request: req/addr stable, Fetch_Req and PC update ignored by the fetch.
      pc_step(1'b0);
      pc_step(1'b0);
      check("pc_8", PC, 32'h8);
      imem_ready = 1'b0;
      Fetch_Req  = 1'b1;
      tick();
      Fetch_Req  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         Fetch_Req = (i == 1);
         PC_LdEn   = (i == 3);
         tick();
         Fetch_Req = 1'b0;
         PC_LdEn   = 1'b0;
         check("stall_req", {31'd0, imem_req}, 32'd1);
         check("stall_addr", imem_addr, 32'h8);
      end
      check("stall_pc", PC, 32'hC);
      imem_ready = 1'b1;
      tick();
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h2108_0001;
      sb_q.push_back(32'h2108_0001);
      tick();
      imem_rvalid = 1'b0;
      wait_valid("stall");
      tick();
      tick();
      tick();
      check("single_txn_busy", {31'd0, Busy}, 32'd0);
      check("single_txn_req", {31'd0, imem_req}, 32'd0);

      // rvalid on the acceptance edge is not captured.
      imem_ready = 1'b1;
      Fetch_Req  = 1'b1;
      tick();
      Fetch_Req   = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1111_1111;
      tick();
      check("early_rv_valid", {31'd0, Instr_Valid}, 32'd0);
      imem_rdata = 32'h2222_2222;
      sb_q.push_back(32'h2222_2222);
      tick();
      imem_rvalid = 1'b0;
      wait_valid("early_rv");

      // Timeout: NOP in IR and a single-cycle error pulse.
      Fetch_Req = 1'b1;
      tick();
      Fetch_Req = 1'b0;
      tick();
      repeat (15) tick();
      check("to_pre_busy", {31'd0, Busy}, 32'd1);
      check("to_pre_err", {31'd0, Fetch_Err}, 32'd0);
      sb_q.push_back(32'h0);
      tick();
      check("to_err", {31'd0, Fetch_Err}, 32'd1);
      check("to_busy", {31'd0, Busy}, 32'd0);
      wait_valid("to");
      tick();
      check("to_err_pulse", {31'd0, Fetch_Err}, 32'd0);

      // Data on the timeout edge wins.
      Fetch_Req = 1'b1;
      tick();
      Fetch_Req = 1'b0;
      tick();
      repeat (15) tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hCAFE_0001;
      sb_q.push_back(32'hCAFE_0001);
      tick();
      imem_rvalid = 1'b0;
      check("to_edge_err", {31'd0, Fetch_Err}, 32'd0);
      wait_valid("to_edge");

      // Asynchronous reset mid-fetch abandons the transaction; late rvalid is dropped.
      Fetch_Req = 1'b1;
      tick();
      Fetch_Req = 1'b0;
      tick();
      tick();
      Reset_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, Busy}, 32'd0);
      check("mid_rst_instr", Instr, 32'h0);
      check("mid_rst_valid", {31'd0, Instr_Valid}, 32'd0);
      check("mid_rst_pc", PC, 32'h0);
      tick();
      Reset_n     = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      check("late_rv_instr", Instr, 32'h0);
      check("late_rv_valid", {31'd0, Instr_Valid}, 32'd0);
      check("late_rv_busy", {31'd0, Busy}, 32'd0);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle control FSM.
- Owns the PC and fetches the word at PC from instruction memory over a req/ready/rvalid handshake.
- Holds the fetched word in an instruction register (IR) that drives the decoder's 32-bit instruction input.
- Applies the PC_LdEn/PC_Sel/PC_Reset commands issued by the control FSM; includes a response-timeout watchdog.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset or PC_Reset.
- TIMEOUT, 16, max cycles waited for imem_rvalid after a request is accepted; must be >= 1.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  one clock; reset is asynchronous and active-low.
- PC_Reset  in  1  synchronous PC reload to PC_RESET.
- PC_LdEn  in  1  PC update strobe from control.
- PC_Sel  in  1  0: PC+4; 1: branch target.
- Fetch_Req  in  1  start a fetch at current PC (single-cycle pulse).
- imem_req  out  1  memory request valid.
- imem_addr  out  32  word-aligned request address.
- imem_ready  in  1  memory accepts request when high with imem_req.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- Instr  out  32  IR contents.
- Instr_Valid  out  1  IR holds the result of the most recent fetch.
- PC  out  32  current PC.
- Busy  out  1  high in REQ or WAIT.
- Fetch_Err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (Reset_n low, asynchronous, any state): PC=PC_RESET, IR=0, Instr_Valid=0, imem_req=0, imem_addr=0, Busy=0, Fetch_Err=0, state=IDLE, timeout counter=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: Fetch_Req=1 -> latch imem_addr<=PC, clear Instr_Valid, go REQ. imem_rvalid is ignored in IDLE.
  - REQ: imem_req=1 with imem_addr stable. imem_req&imem_ready at an edge -> clear counter, go WAIT.
  - WAIT: imem_rvalid=1 -> IR<=imem_rdata, Instr_Valid<=1, go IDLE.
  - WAIT timeout: counter reaches TIMEOUT-1 without imem_rvalid -> IR<=32'h0 (decoded downstream as NOP), Instr_Valid<=1, Fetch_Err pulses 1 cycle, go IDLE.
- Latency: Fetch_Req at edge N, imem_ready already high -> request accepted at N+1. rvalid at N+1+k -> Instr_Valid high in the cycle after that edge.
- Fetch_Req while Busy is ignored; no queuing.
- PC update:
  - Evaluated every edge regardless of FSM state. imem_addr is captured at request launch, so an in-flight fetch is unaffected.
  - Priority: PC_Reset > PC_LdEn.
  - PC_LdEn & !PC_Sel: PC<=PC+4.
  - PC_LdEn & PC_Sel: PC<=PC+4+(sign_extend(IR[15:0])<<2).
  - Arithmetic is modulo 2^32; wrap-around is silent.
  - PC[1:0] is always 0. imem_addr[1:0] is forced to 0.
- IR changes only on fetch completion or reset. Instr is stable for the whole decode/execute sequence.
- imem_rvalid in the same cycle as the REQ acceptance belongs to WAIT of the next cycle only. rvalid together with the timeout edge: data wins, no Fetch_Err.
- Reset asserted mid-fetch: the transaction is abandoned. A late imem_rvalid arriving in IDLE is dropped.

Test Plan:
- Reset, then Fetch_Req with imem_ready=1 and rvalid 2 cycles later, rdata=32'h8C22_0004 -> imem_addr=0, Instr=32'h8C22_0004, Instr_Valid=1, PC=0.
- PC=32'h100, PC_LdEn=1, PC_Sel=0 -> PC=32'h104. Then IR[15:0]=16'hFFFE, PC_Sel=1 -> PC=32'h104+4-8=32'h100.
- PC=32'hFFFF_FFFC, PC_LdEn=1, PC_Sel=0 -> PC=32'h0. PC_Reset and PC_LdEn together -> PC=PC_RESET.
- imem_ready held low 5 cycles -> imem_req and imem_addr held stable. Fetch_Req pulsed during this wait -> no effect, a single transaction completes.
- No imem_rvalid for TIMEOUT=16 cycles -> Instr=32'h0, Instr_Valid=1, Fetch_Err high exactly 1 cycle, Busy=0.
- Reset_n low during WAIT, then rvalid with 32'hDEAD_BEEF -> Instr=0, Instr_Valid=0, state IDLE.
